program_sequencer: RTL and testbench



---
 rtl/program_sequencer_if.sv | 31 +++
 rtl/program_sequencer.sv | 98 +++++++++
 tb/tb_program_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Program sequencer bus: branch strobes and target in, fetch address and
// sequencer status out. The sequencer takes the master side.
interface program_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    logic              hold;
    logic              jmp;
    logic              jmp_nz;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] jmp_addr;
    logic              r_eq_0;
    logic [ADDR_W-1:0] pm_addr;
    logic [ADDR_W-1:0] pc;
    logic [SPW-1:0]    sp;
    logic              stack_err;
    logic [7:0]        from_PS;

    modport master (
        input  hold, jmp, jmp_nz, call, ret, jmp_addr, r_eq_0,
        output pm_addr, pc, sp, stack_err, from_PS
    );

    modport slave (
        output hold, jmp, jmp_nz, call, ret, jmp_addr, r_eq_0,
        input  pm_addr, pc, sp, stack_err, from_PS
    );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: program counter, combinational next-fetch address,
// jump / conditional jump / call / return with a small LIFO return stack.
module program_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input logic               clk,
    input logic               reset_n,
    program_sequencer_if.master bus
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;
    localparam int IW  = SPW - 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stk_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [IW-1:0]     push_idx, top_idx;
    logic              stk_full, stk_empty;
    logic              push;

    assign pc_inc    = pc_q + ADDR_W'(1);
    // Index bits alone address the stack; at sp == STACK_DEPTH they wrap to 0,
    // so top_idx still lands on the last entry.
    assign push_idx  = sp_q[IW-1:0];
    assign top_idx   = sp_q[IW-1:0] - IW'(1);
    assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stk_empty = (sp_q == '0);

    // Next-address select in priority order, plus stack/err bookkeeping.
    always_comb begin
        pc_d  = pc_inc;
        sp_d  = sp_q;
        err_d = err_q;
        push  = 1'b0;
        if (!reset_n) begin
            pc_d = '0;
        end else if (bus.hold) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            if (!stk_empty) begin
                pc_d = stk_q[top_idx];
                sp_d = sp_q - SPW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.call) begin
            pc_d = bus.jmp_addr;
            if (stk_full) begin
                err_d = 1'b1;
            end else begin
                push = 1'b1;
                sp_d = sp_q + SPW'(1);
            end
        end else if (bus.jmp) begin
            pc_d = bus.jmp_addr;
        end else if (bus.jmp_nz && !bus.r_eq_0) begin
            pc_d = bus.jmp_addr;
        end
    end

    // PC, stack pointer and sticky error register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return stack storage; a pop only moves sp, contents stay put.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
        end else if (push) begin
            stk_q[push_idx] <= pc_inc;
        end
    end

    assign bus.pm_addr   = pc_d;
    assign bus.pc        = pc_q;
    assign bus.sp        = sp_q;
    assign bus.stack_err = err_q;

    generate
        if (ADDR_W >= 8) begin : g_dbg_trunc
            assign bus.from_PS = pc_q[7:0];
        end else begin : g_dbg_ext
            assign bus.from_PS = {{(8-ADDR_W){1'b0}}, pc_q};
        end
    endgenerate
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    program_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) sif ();

    program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sif.hold = 0; sif.jmp = 0; sif.jmp_nz = 0; sif.call = 0; sif.ret = 0;
        sif.jmp_addr = '0; sif.r_eq_0 = 0;
    endtask

    task automatic jump_to(input logic [7:0] a);
        idle(); sif.jmp = 1; sif.jmp_addr = a;
        step(); idle();
    endtask

    initial begin
        idle();
        reset_n = 0;
        // reset held for 3 cycles
        repeat (3) step();
        chk("rst_pc", sif.pc, 0);
        chk("rst_sp", sif.sp, 0);
        chk("rst_err", sif.stack_err, 0);
        chk("rst_pm", sif.pm_addr, 0);
        reset_n = 1;
        #1;
        chk("free_pm", sif.pm_addr, 1);
        step(); chk("free_pc1", sif.pc, 1);
        step(); chk("free_pc2", sif.pc, 2);
        step(); chk("free_pc3", sif.pc, 3);
        chk("free_sp", sif.sp, 0);

        // wrap 255 -> 0
        repeat (252) step();
        chk("wrap_pc", sif.pc, 8'hFF);
        chk("wrap_pm", sif.pm_addr, 0);
        chk("wrap_dbg", sif.from_PS, 8'hFF);
        step(); chk("wrap_pc0", sif.pc, 0);

        // conditional jump
        repeat (16) step();
        chk("jnz_at", sif.pc, 8'h10);
        sif.jmp_nz = 1; sif.jmp_addr = 8'h40; sif.r_eq_0 = 1; #1;
        chk("jnz_z_pm", sif.pm_addr, 8'h11);
        step(); chk("jnz_z_pc", sif.pc, 8'h11);
        sif.r_eq_0 = 0; #1;
        chk("jnz_nz_pm", sif.pm_addr, 8'h40);
        step(); chk("jnz_nz_pc", sif.pc, 8'h40);
        idle();

        // nested call / return
        jump_to(8'h05);
        chk("call_at", sif.pc, 8'h05);
        sif.call = 1; sif.jmp_addr = 8'h20; step(); idle();
        chk("call1_pc", sif.pc, 8'h20);
        chk("call1_sp", sif.sp, 1);
        step(); step();
        sif.call = 1; sif.jmp_addr = 8'h30; step(); idle();
        chk("call2_pc", sif.pc, 8'h30);
        chk("call2_sp", sif.sp, 2);
        sif.ret = 1; #1;
        chk("ret1_pm", sif.pm_addr, 8'h23);
        step();
        chk("ret1_pc", sif.pc, 8'h23);
        chk("ret1_sp", sif.sp, 1);
        step(); idle();
        chk("ret2_pc", sif.pc, 8'h06);
        chk("ret2_sp", sif.sp, 0);
        chk("ret2_err", sif.stack_err, 0);

        // hold overrides strobes and suppresses the push
        jump_to(8'h12);
        sif.hold = 1; sif.jmp = 1; sif.call = 1; sif.jmp_addr = 8'h77; #1;
        chk("hold_pm", sif.pm_addr, 8'h12);
        step(); idle();
        chk("hold_pc", sif.pc, 8'h12);
        chk("hold_sp", sif.sp, 0);

        // call wins over jmp: target taken and return address pushed
        sif.call = 1; sif.jmp = 1; sif.jmp_addr = 8'h50; step(); idle();
        chk("prio_pc", sif.pc, 8'h50);
        chk("prio_sp", sif.sp, 1);
        sif.ret = 1; step(); idle();
        chk("prio_ret", sif.pc, 8'h13);

        // overflow: four pushes fit, the fifth jumps but does not push
        for (int i = 0; i < 4; i++) begin
            sif.call = 1; sif.jmp_addr = 8'h60 + 8'(i); step(); idle();
        end
        chk("ovf4_sp", sif.sp, 4);
        chk("ovf4_err", sif.stack_err, 0);
        sif.call = 1; sif.jmp_addr = 8'h70; step(); idle();
        chk("ovf5_pc", sif.pc, 8'h70);
        chk("ovf5_sp", sif.sp, 4);
        chk("ovf5_err", sif.stack_err, 1);
        sif.ret = 1; step(); idle();
        chk("ovf_ret_pc", sif.pc, 8'h63);
        chk("ovf_ret_sp", sif.sp, 3);
        chk("ovf_sticky", sif.stack_err, 1);

        // asynchronous reset mid-sequence
        reset_n = 0; #1;
        chk("arst_pc", sif.pc, 0);
        chk("arst_sp", sif.sp, 0);
        chk("arst_err", sif.stack_err, 0);
        chk("arst_pm", sif.pm_addr, 0);
        step();
        reset_n = 1;
        step(); chk("arst_run", sif.pc, 1);

        // underflow after reset
        repeat (7) step();
        chk("unf_at", sif.pc, 8'h08);
        sif.ret = 1; #1;
        chk("unf_pm", sif.pm_addr, 8'h09);
        step(); idle();
        chk("unf_pc", sif.pc, 8'h09);
        chk("unf_sp", sif.sp, 0);
        chk("unf_err", sif.stack_err, 1);

        // return address wraps: call at 0xFF returns to 0x00
        jump_to(8'hFF);
        sif.call = 1; sif.jmp_addr = 8'h10; step(); idle();
        chk("wcall_pc", sif.pc, 8'h10);
        sif.ret = 1; step(); idle();
        chk("wret_pc", sif.pc, 8'h00);
        chk("wret_sp", sif.sp, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
